ht_cmd_arbiter: RTL and testbench
=================================

Name: ht_cmd_arbiter

Overview:
- Multi-channel command front end for the hash table core: merges CH_CNT independent ht_command_t streams into the single core command port using round-robin arbitration.
- Routes each in-order ht_result_t back to the issuing channel through a channel-ID tag FIFO.
- Enforces OP_INIT as a full fence, so a table clear never overlaps in-flight search, insert or delete commands.
- Sits between the client logic and the hash table pipeline input/output.

Parameters:
- CH_CNT, 4, number of client channels (2..16).
- MAX_OUTSTANDING, 16, tag FIFO depth (power of two) = maximum commands in flight in the core.
- CH_W, $clog2(CH_CNT), local; channel-ID width.
- CNT_W, $clog2(MAX_OUTSTANDING+1), local; outstanding counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- cmd_i  in  CH_CNT x ht_command_t  per-channel command
- cmd_valid_i  in  CH_CNT  per-channel command valid
- cmd_ready_o  out  CH_CNT  per-channel accept (at most one bit high)
- ht_cmd_o  out  ht_command_t  command to core
- ht_cmd_valid_o  out  1  command valid to core
- ht_cmd_ready_i  in  1  core accepts command
- ht_res_i  in  ht_result_t  result from core (in order)
- ht_res_valid_i  in  1  result valid
- ht_res_ready_o  out  1  arbiter accepts result
- res_o  out  ht_result_t  result, broadcast to all channels
- res_valid_o  out  CH_CNT  one-hot result valid for the owning channel
- res_ready_i  in  CH_CNT  per-channel result ready
- outstanding_o  out  CNT_W  commands issued whose results have not yet been accepted
- err_unexp_res_o  out  1  sticky: result arrived while the tag FIFO was empty
- stat_grant_cnt_o  out  CH_CNT x 32  per-channel grant counters (optional feature)

Behaviour:
- Reset values: all valids, readies, outstanding_o, err_unexp_res_o and counters = 0; RR pointer = 0; state = ARB; res_o and ht_cmd_o = 0.
- Handshakes: valid/ready. A transfer occurs when valid && ready are both high on a rising edge. Valid must not depend on ready. Data is held stable while valid is high and ready is low.
- Command output: a single registered stage. The register is "free" when ht_cmd_valid_o == 0 or ht_cmd_ready_i == 1.
- Command latency: 1 cycle from the cmd_valid_i handshake to ht_cmd_valid_o.
- Grant condition, all required: register free, tag FIFO not full, state permits (see FSM).
- Round-robin selection: the first valid channel starting from the RR pointer. cmd_ready_o is high only for the granted channel. After a grant, the pointer becomes (granted + 1) mod CH_CNT.
- Tag FIFO: on each grant, the channel ID is pushed and outstanding_o increments.
- Result path: a registered stage; res_valid_o is one-hot at the FIFO head channel.
  - ht_res_ready_o = result register empty, or the owning channel's res_ready_i is high.
  - On an ht_res handshake, the FIFO is popped and outstanding_o decrements.
  - Push and pop in the same cycle leave outstanding_o unchanged.
- Unexpected result (tag FIFO empty): the result is accepted and dropped; err_unexp_res_o sets and stays set until reset.
- FSM:
  - ARB: normal grants.
    - If the selected channel presents OP_INIT and outstanding_o != 0, go to FENCE_PRE and grant nothing.
    - If OP_INIT is granted with outstanding_o == 0, go to FENCE_POST.
  - FENCE_PRE: no grants; the RR pointer is frozen on the INIT channel. When outstanding_o == 0, return to ARB, which grants the INIT.
  - FENCE_POST: no grants. When outstanding_o == 0 (INIT result accepted), return to ARB.
- Boundaries:
  - MAX_OUTSTANDING reached: no grant until a pop occurs; a pop in the same cycle does not enable the grant (registered full flag).
  - Channel holding cmd_valid_i: cannot starve others, because RR guarantees service within CH_CNT grants.
  - Reset mid-operation: all in-flight tags are discarded. The core must be reset together with this block.

Optional Feature:
- Macro: HT_ARB_STATS_EN.
- Defined: 32-bit per-channel counters increment on each grant, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: the counters are not built and stat_grant_cnt_o is tied to 0. The port list is unchanged.

Decomposition:
- Package hash_table gains:
  - ht_arb_state_t enum {ARB, FENCE_PRE, FENCE_POST}
  - HT_MAX_CH = 16
- One sub-module, ht_tag_fifo: a synchronous FIFO of CH_W-bit entries with depth MAX_OUTSTANDING, full/empty/usedw outputs and the same asynchronous active-low reset.

Test Plan:
- Round robin: all 4 channels hold valid SEARCH commands, core always ready → grant order 0,1,2,3,0,1…; each channel receives its own results with rescode SEARCH_*.
- Backpressure: ht_cmd_ready_i low for 5 cycles → ht_cmd_o stable; no cmd_ready_o high for a second command.
- Full: core never returns results → 16 grants, then cmd_ready_o = 0 and outstanding_o = 16. One result returns → next grant one cycle later.
- INIT fence: 3 inserts outstanding, channel 2 sends OP_INIT → no grant until outstanding_o = 0. INIT is issued alone, and other channels stall until INIT_SUCCESS is delivered on res_valid_o[2].
- Result stall: channel 1 res_ready_i low with its result at the head → ht_res_ready_o = 0, no result loss; order is preserved after release.
- Error: inject ht_res_valid_i with outstanding_o = 0 → err_unexp_res_o = 1 and stays 1; with HT_ARB_STATS_EN defined, counters match grant counts.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared hash table types: command/result records, opcodes, result codes and
// the multi-channel arbiter state encoding.
package hash_table;

  localparam int KEY_W     = 16;
  localparam int VALUE_W   = 16;
  localparam int HT_MAX_CH = 16;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_SEARCH = 2'd1,
    OP_INSERT = 2'd2,
    OP_DELETE = 2'd3
  } ht_opcode_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND                     = 3'd0,
    SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
    INSERT_SUCCESS                   = 3'd2,
    INSERT_SUCCESS_SAME_KEY          = 3'd3,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
    DELETE_SUCCESS                   = 3'd5,
    DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6,
    INIT_SUCCESS                     = 3'd7
  } ht_rescode_t;

  typedef struct packed {
    ht_opcode_t           opcode;
    logic [KEY_W-1:0]     key;
    logic [VALUE_W-1:0]   value;
  } ht_command_t;

  typedef struct packed {
    ht_command_t          cmd;
    ht_rescode_t          rescode;
    logic [VALUE_W-1:0]   found_value;
  } ht_result_t;

  typedef enum logic [1:0] {
    ARB        = 2'd0,
    FENCE_PRE  = 2'd1,
    FENCE_POST = 2'd2
  } ht_arb_state_t;

endpackage

// File: rtl/ht_cmd_arbiter_tag_fifo.sv
// Channel-ID tag FIFO: remembers which channel issued each in-flight command
// so in-order results can be steered back. Power-of-two depth.
module ht_tag_fifo
  import hash_table::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] usedw_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign full_o    = (r_cnt == CNT_W'(DEPTH));
  assign empty_o   = (r_cnt == '0);
  assign usedw_o   = r_cnt;
  assign rd_data_o = r_mem[r_rd_ptr];
  assign w_wr      = wr_en_i && !full_o;
  assign w_rd      = rd_en_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ht_cmd_arbiter.sv
// Round-robin command arbiter for the hash table core with OP_INIT fencing
// and tag-steered results. Optional per-channel grant counters: HT_ARB_STATS_EN.
module ht_cmd_arbiter
  import hash_table::*;
#(
  parameter  int CH_CNT          = 4,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int CH_W            = $clog2(CH_CNT),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  ht_command_t         cmd_i [CH_CNT],
  input  logic [CH_CNT-1:0]   cmd_valid_i,
  output logic [CH_CNT-1:0]   cmd_ready_o,
  output ht_command_t         ht_cmd_o,
  output logic                ht_cmd_valid_o,
  input  logic                ht_cmd_ready_i,
  input  ht_result_t          ht_res_i,
  input  logic                ht_res_valid_i,
  output logic                ht_res_ready_o,
  output ht_result_t          res_o,
  output logic [CH_CNT-1:0]   res_valid_o,
  input  logic [CH_CNT-1:0]   res_ready_i,
  output logic [CNT_W-1:0]    outstanding_o,
  output logic                err_unexp_res_o,
  output logic [31:0]         stat_grant_cnt_o [CH_CNT]
);

  ht_arb_state_t     r_state;
  ht_arb_state_t     w_state_nxt;
  logic [CH_W-1:0]   r_ptr;
  logic [CH_W-1:0]   w_sel;
  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_ptr_inc;
  logic              w_any_vld;
  logic              w_sel_init;
  logic              w_cmd_free;
  logic              w_grant;
  logic              w_fence_enter;

  ht_command_t       r_cmd;
  logic              r_cmd_vld;
  ht_result_t        r_res;
  logic [CH_CNT-1:0] r_res_vld;
  logic              r_err;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CH_W-1:0]   w_fifo_head;
  logic [CNT_W-1:0]  w_used;
  logic              w_res_taken;
  logic              w_res_hs;
  logic              w_pop;
  logic              w_unexp;

  // Round-robin pick: lowest offset from r_ptr wins, so scan from the far end.
  always_comb begin
    w_any_vld = 1'b0;
    w_sel     = '0;
    w_idx     = '0;
    for (int i = CH_CNT - 1; i >= 0; i--) begin
      w_idx = CH_W'((int'(r_ptr) + i) % CH_CNT);
      if (cmd_valid_i[w_idx]) begin
        w_any_vld = 1'b1;
        w_sel     = w_idx;
      end
    end
  end

  assign w_sel_init = (cmd_i[w_sel].opcode == OP_INIT);
  assign w_cmd_free = !r_cmd_vld || ht_cmd_ready_i;
  assign w_ptr_inc  = (w_sel == CH_W'(CH_CNT - 1)) ? '0 : w_sel + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_fence_enter = 1'b0;
    case (r_state)
      ARB: begin
        if (w_any_vld) begin
          if (w_sel_init && (w_used != '0)) begin
            w_state_nxt   = FENCE_PRE;
            w_fence_enter = 1'b1;
          end else if (w_cmd_free && !w_fifo_full) begin
            w_grant = 1'b1;
            if (w_sel_init) w_state_nxt = FENCE_POST;
          end
        end
      end
      FENCE_PRE, FENCE_POST: begin
        if (w_used == '0) w_state_nxt = ARB;
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ARB;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant)            r_ptr <= w_ptr_inc;
      else if (w_fence_enter) r_ptr <= w_sel;
    end
  end

  assign cmd_ready_o = w_grant ? (CH_CNT'(1) << w_sel) : '0;

  // ---- command output stage ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cmd     <= '0;
      r_cmd_vld <= 1'b0;
    end else if (w_grant) begin
      r_cmd     <= cmd_i[w_sel];
      r_cmd_vld <= 1'b1;
    end else if (ht_cmd_ready_i) begin
      r_cmd_vld <= 1'b0;
    end
  end

  assign ht_cmd_o       = r_cmd;
  assign ht_cmd_valid_o = r_cmd_vld;

  ht_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (w_grant),
    .wr_data_i (w_sel),
    .rd_en_i   (w_pop),
    .rd_data_o (w_fifo_head),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty),
    .usedw_o   (w_used)
  );

  assign outstanding_o = w_used;

  // ---- result output stage ----
  assign w_res_taken    = |(r_res_vld & res_ready_i);
  assign ht_res_ready_o = !(|r_res_vld) || w_res_taken;
  assign w_res_hs       = ht_res_valid_i && ht_res_ready_o;
  assign w_pop          = w_res_hs && !w_fifo_empty;
  assign w_unexp        = w_res_hs && w_fifo_empty;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_res     <= '0;
      r_res_vld <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_pop) begin
        r_res     <= ht_res_i;
        r_res_vld <= CH_CNT'(1) << w_fifo_head;
      end else if (w_res_taken) begin
        r_res_vld <= '0;
      end
      if (w_unexp) r_err <= 1'b1;
    end
  end

  assign res_o           = r_res;
  assign res_valid_o     = r_res_vld;
  assign err_unexp_res_o = r_err;

`ifdef HT_ARB_STATS_EN
  logic [31:0] r_stat [CH_CNT];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < CH_CNT; i++) r_stat[i] <= '0;
    end else if (w_grant && (r_stat[w_sel] != 32'hFFFF_FFFF)) begin
      r_stat[w_sel] <= r_stat[w_sel] + 32'd1;
    end
  end

  for (genvar g = 0; g < CH_CNT; g++) begin : g_stat
    assign stat_grant_cnt_o[g] = r_stat[g];
  end
`else
  for (genvar g = 0; g < CH_CNT; g++) begin : g_stat
    assign stat_grant_cnt_o[g] = '0;
  end
`endif

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Directed testbench for ht_cmd_arbiter (4 channels, 16 outstanding).
module tb_ht_cmd_arbiter;
  import hash_table::*;

  logic        clk = 1'b0;
  logic        rst_i;
  ht_command_t cmd_i [4];
  logic [3:0]  cmd_valid_i;
  logic [3:0]  cmd_ready_o;
  ht_command_t ht_cmd_o;
  logic        ht_cmd_valid_o;
  logic        ht_cmd_ready_i;
  ht_result_t  ht_res_i;
  logic        ht_res_valid_i;
  logic        ht_res_ready_o;
  ht_result_t  res_o;
  logic [3:0]  res_valid_o;
  logic [3:0]  res_ready_i;
  logic [4:0]  outstanding_o;
  logic        err_unexp_res_o;
  logic [31:0] stat_grant_cnt_o [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ht_cmd_arbiter #(.CH_CNT(4), .MAX_OUTSTANDING(16)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .cmd_i            (cmd_i),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .ht_cmd_o         (ht_cmd_o),
    .ht_cmd_valid_o   (ht_cmd_valid_o),
    .ht_cmd_ready_i   (ht_cmd_ready_i),
    .ht_res_i         (ht_res_i),
    .ht_res_valid_i   (ht_res_valid_i),
    .ht_res_ready_o   (ht_res_ready_o),
    .res_o            (res_o),
    .res_valid_o      (res_valid_o),
    .res_ready_i      (res_ready_i),
    .outstanding_o    (outstanding_o),
    .err_unexp_res_o  (err_unexp_res_o),
    .stat_grant_cnt_o (stat_grant_cnt_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  function automatic ht_command_t mk_cmd(ht_opcode_t op, logic [15:0] key);
    ht_command_t c;
    c.opcode = op;
    c.key    = key;
    c.value  = key ^ 16'h5A5A;
    return c;
  endfunction

  function automatic ht_result_t mk_res(ht_command_t c, ht_rescode_t rc);
    ht_result_t r;
    r.cmd         = c;
    r.rescode     = rc;
    r.found_value = 16'h0;
    return r;
  endfunction

  task automatic test_reset;
    rst_i          = 1'b0;
    cmd_valid_i    = '0;
    ht_cmd_ready_i = 1'b1;
    ht_res_valid_i = 1'b0;
    ht_res_i       = '0;
    res_ready_i    = 4'hF;
    for (int c = 0; c < 4; c++) cmd_i[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (ht_cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b want 0", ht_cmd_valid_o); end
    n_tests++; if (cmd_ready_o !== 4'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0000", cmd_ready_o); end
    n_tests++; if (res_valid_o !== 4'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0000", res_valid_o); end
    n_tests++; if (outstanding_o !== 5'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
    n_tests++; if (err_unexp_res_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_unexp_res_o); end
    n_tests++; if (ht_cmd_o !== '0 || res_o !== '0) begin n_fail++; $display("FAIL reset_data: got cmd %h res %h want 0", ht_cmd_o, res_o); end
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_round_robin;
    logic [3:0]  e;
    logic [15:0] ek;
    for (int c = 0; c < 4; c++) cmd_i[c] = mk_cmd(OP_SEARCH, 16'h100 + 16'(c));
    cmd_valid_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      e  = 4'b0001 << (i % 4);
      ek = 16'h100 + 16'(i % 4);
      settle();
      n_tests++; if (cmd_ready_o !== e) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, cmd_ready_o, e); end
      tick();
      n_tests++; if (ht_cmd_valid_o !== 1'b1 || ht_cmd_o.key !== ek) begin n_fail++; $display("FAIL rr_cmd[%0d]: got v=%b key=%h want v=1 key=%h", i, ht_cmd_valid_o, ht_cmd_o.key, ek); end
    end
    cmd_valid_i = '0;
    n_tests++; if (outstanding_o !== 5'd8) begin n_fail++; $display("FAIL rr_outstanding: got %0d want 8", outstanding_o); end
    tick();
    for (int j = 0; j < 8; j++) begin
      e  = 4'b0001 << (j % 4);
      ek = 16'h100 + 16'(j % 4);
      ht_res_i = mk_res(mk_cmd(OP_SEARCH, ek), (j % 2 == 1) ? SEARCH_NOT_SUCCESS_NO_ENTRY : SEARCH_FOUND);
      ht_res_valid_i = 1'b1;
      settle();
      n_tests++; if (ht_res_ready_o !== 1'b1) begin n_fail++; $display("FAIL rr_res_ready[%0d]: got %b want 1", j, ht_res_ready_o); end
      tick();
      n_tests++; if (res_valid_o !== e || res_o.cmd.key !== ek) begin n_fail++; $display("FAIL rr_res_route[%0d]: got v=%b key=%h want v=%b key=%h", j, res_valid_o, res_o.cmd.key, e, ek); end
      n_tests++; if (res_o.rescode !== ((j % 2 == 1) ? SEARCH_NOT_SUCCESS_NO_ENTRY : SEARCH_FOUND)) begin n_fail++; $display("FAIL rr_rescode[%0d]: got %0d", j, res_o.rescode); end
    end
    ht_res_valid_i = 1'b0;
    tick();
    n_tests++; if (res_valid_o !== 4'b0 || outstanding_o !== 5'd0) begin n_fail++; $display("FAIL rr_drain: got v=%b out=%0d want 0000/0", res_valid_o, outstanding_o); end
  endtask

  task automatic test_backpressure;
    logic [3:0] exp_ch [2];
    exp_ch[0] = 4'b0010;
    exp_ch[1] = 4'b1000;
    ht_cmd_ready_i = 1'b0;
    cmd_i[1] = mk_cmd(OP_INSERT, 16'h201);
    cmd_i[3] = mk_cmd(OP_DELETE, 16'h203);
    cmd_valid_i = 4'b1010;
    settle();
    n_tests++; if (cmd_ready_o !== 4'b0010) begin n_fail++; $display("FAIL bp_first_grant: got %b want 0010", cmd_ready_o); end
    tick();
    cmd_valid_i = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      settle();
      n_tests++; if (cmd_ready_o !== 4'b0) begin n_fail++; $display("FAIL bp_no_grant[%0d]: got %b want 0000", k, cmd_ready_o); end
      n_tests++; if (ht_cmd_valid_o !== 1'b1 || ht_cmd_o !== mk_cmd(OP_INSERT, 16'h201)) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b key=%h want v=1 key=0201", k, ht_cmd_valid_o, ht_cmd_o.key); end
      tick();
    end
    ht_cmd_ready_i = 1'b1;
    settle();
    n_tests++; if (cmd_ready_o !== 4'b1000) begin n_fail++; $display("FAIL bp_release_grant: got %b want 1000", cmd_ready_o); end
    tick();
    cmd_valid_i = '0;
    n_tests++; if (ht_cmd_valid_o !== 1'b1 || ht_cmd_o.key !== 16'h203) begin n_fail++; $display("FAIL bp_second_cmd: got v=%b key=%h want v=1 key=0203", ht_cmd_valid_o, ht_cmd_o.key); end
    tick();
    n_tests++; if (ht_cmd_valid_o !== 1'b0 || outstanding_o !== 5'd2) begin n_fail++; $display("FAIL bp_idle: got v=%b out=%0d want 0/2", ht_cmd_valid_o, outstanding_o); end
    for (int j = 0; j < 2; j++) begin
      ht_res_i = mk_res(mk_cmd(OP_INSERT, 16'h200), INSERT_SUCCESS);
      ht_res_valid_i = 1'b1;
      tick();
      n_tests++; if (res_valid_o !== exp_ch[j]) begin n_fail++; $display("FAIL bp_res_route[%0d]: got %b want %b", j, res_valid_o, exp_ch[j]); end
    end
    ht_res_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_full;
    cmd_i[0] = mk_cmd(OP_SEARCH, 16'h300);
    cmd_valid_i = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      settle();
      n_tests++; if (cmd_ready_o !== 4'b0001) begin n_fail++; $display("FAIL full_grant[%0d]: got %b want 0001", i, cmd_ready_o); end
      tick();
    end
    settle();
    n_tests++; if (cmd_ready_o !== 4'b0 || outstanding_o !== 5'd16) begin n_fail++; $display("FAIL full_stop: got rdy=%b out=%0d want 0000/16", cmd_ready_o, outstanding_o); end
    tick();
    ht_res_i = mk_res(cmd_i[0], SEARCH_FOUND);
    ht_res_valid_i = 1'b1;
    settle();
    n_tests++; if (ht_res_ready_o !== 1'b1 || cmd_ready_o !== 4'b0) begin n_fail++; $display("FAIL full_pop_cycle: got res_rdy=%b rdy=%b want 1/0000", ht_res_ready_o, cmd_ready_o); end
    tick();
    ht_res_valid_i = 1'b0;
    settle();
    n_tests++; if (outstanding_o !== 5'd15 || cmd_ready_o !== 4'b0001) begin n_fail++; $display("FAIL full_after_pop: got out=%0d rdy=%b want 15/0001", outstanding_o, cmd_ready_o); end
    tick();
    cmd_valid_i = '0;
    n_tests++; if (outstanding_o !== 5'd16) begin n_fail++; $display("FAIL full_refill: got %0d want 16", outstanding_o); end
    ht_res_valid_i = 1'b1;
    repeat (16) tick();
    ht_res_valid_i = 1'b0;
    tick();
    n_tests++; if (outstanding_o !== 5'd0) begin n_fail++; $display("FAIL full_drain: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_init_fence;
    cmd_i[0] = mk_cmd(OP_INSERT, 16'h400);
    cmd_valid_i = 4'b0001;
    repeat (3) begin settle(); tick(); end
    cmd_valid_i = '0;
    n_tests++; if (outstanding_o !== 5'd3) begin n_fail++; $display("FAIL init_pre_outstanding: got %0d want 3", outstanding_o); end
    cmd_i[2] = mk_cmd(OP_INIT, 16'h0);
    cmd_valid_i = 4'b0100;
    settle();
    n_tests++; if (cmd_ready_o !== 4'b0) begin n_fail++; $display("FAIL init_blocked: got %b want 0000", cmd_ready_o); end
    tick();
    cmd_i[0] = mk_cmd(OP_SEARCH, 16'h401);
    cmd_valid_i = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      ht_res_i = mk_res(mk_cmd(OP_INSERT, 16'h400), INSERT_SUCCESS);
      ht_res_valid_i = 1'b1;
      settle();
      n_tests++; if (cmd_ready_o !== 4'b0) begin n_fail++; $display("FAIL init_fence_pre[%0d]: got %b want 0000", k, cmd_ready_o); end
      tick();
    end
    ht_res_valid_i = 1'b0;
    settle();
    n_tests++; if (cmd_ready_o !== 4'b0 || outstanding_o !== 5'd0) begin n_fail++; $display("FAIL init_fence_exit: got rdy=%b out=%0d want 0000/0", cmd_ready_o, outstanding_o); end
    tick();
    n_tests++; if (cmd_ready_o !== 4'b0100) begin n_fail++; $display("FAIL init_grant: got %b want 0100", cmd_ready_o); end
    tick();
    cmd_valid_i = 4'b0001;
    settle();
    n_tests++; if (ht_cmd_valid_o !== 1'b1 || ht_cmd_o.opcode !== OP_INIT) begin n_fail++; $display("FAIL init_issued: got v=%b op=%0d want 1/INIT", ht_cmd_valid_o, ht_cmd_o.opcode); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (cmd_ready_o !== 4'b0 || outstanding_o !== 5'd1) begin n_fail++; $display("FAIL init_fence_post[%0d]: got rdy=%b out=%0d want 0000/1", k, cmd_ready_o, outstanding_o); end
      tick();
    end
    ht_res_i = mk_res(mk_cmd(OP_INIT, 16'h0), INIT_SUCCESS);
    ht_res_valid_i = 1'b1;
    settle();
    n_tests++; if (cmd_ready_o !== 4'b0) begin n_fail++; $display("FAIL init_res_cycle: got %b want 0000", cmd_ready_o); end
    tick();
    ht_res_valid_i = 1'b0;
    settle();
    n_tests++; if (res_valid_o !== 4'b0100 || res_o.rescode !== INIT_SUCCESS) begin n_fail++; $display("FAIL init_res_route: got v=%b rc=%0d want 0100/INIT_SUCCESS", res_valid_o, res_o.rescode); end
    n_tests++; if (cmd_ready_o !== 4'b0) begin n_fail++; $display("FAIL init_res_stall: got %b want 0000", cmd_ready_o); end
    tick();
    n_tests++; if (cmd_ready_o !== 4'b0001) begin n_fail++; $display("FAIL init_resume: got %b want 0001", cmd_ready_o); end
    tick();
    cmd_valid_i = '0;
    ht_res_valid_i = 1'b1;
    tick();
    ht_res_valid_i = 1'b0;
    tick();
    n_tests++; if (outstanding_o !== 5'd0) begin n_fail++; $display("FAIL init_drain: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_result_stall;
    cmd_i[1] = mk_cmd(OP_SEARCH, 16'h501);
    cmd_i[2] = mk_cmd(OP_SEARCH, 16'h502);
    cmd_valid_i = 4'b0110;
    settle();
    n_tests++; if (cmd_ready_o !== 4'b0010) begin n_fail++; $display("FAIL stall_grant1: got %b want 0010", cmd_ready_o); end
    tick();
    settle();
    n_tests++; if (cmd_ready_o !== 4'b0100) begin n_fail++; $display("FAIL stall_grant2: got %b want 0100", cmd_ready_o); end
    tick();
    cmd_valid_i = '0;
    res_ready_i = 4'b1101;
    ht_res_i = mk_res(cmd_i[1], SEARCH_FOUND);
    ht_res_valid_i = 1'b1;
    settle();
    n_tests++; if (ht_res_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_first_accept: got %b want 1", ht_res_ready_o); end
    tick();
    ht_res_i = mk_res(cmd_i[2], SEARCH_NOT_SUCCESS_NO_ENTRY);
    settle();
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (ht_res_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_res_ready[%0d]: got %b want 0", k, ht_res_ready_o); end
      n_tests++; if (res_valid_o !== 4'b0010 || res_o.cmd.key !== 16'h501 || outstanding_o !== 5'd1) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b key=%h out=%0d want 0010/0501/1", k, res_valid_o, res_o.cmd.key, outstanding_o); end
      tick();
    end
    res_ready_i = 4'hF;
    settle();
    n_tests++; if (ht_res_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", ht_res_ready_o); end
    tick();
    ht_res_valid_i = 1'b0;
    n_tests++; if (res_valid_o !== 4'b0100 || res_o.cmd.key !== 16'h502) begin n_fail++; $display("FAIL stall_order: got v=%b key=%h want 0100/0502", res_valid_o, res_o.cmd.key); end
    tick();
    n_tests++; if (res_valid_o !== 4'b0 || outstanding_o !== 5'd0) begin n_fail++; $display("FAIL stall_drain: got v=%b out=%0d want 0000/0", res_valid_o, outstanding_o); end
  endtask

  task automatic test_error;
    ht_res_i = mk_res(mk_cmd(OP_SEARCH, 16'h600), SEARCH_FOUND);
    ht_res_valid_i = 1'b1;
    settle();
    n_tests++; if (ht_res_ready_o !== 1'b1) begin n_fail++; $display("FAIL err_accept: got %b want 1", ht_res_ready_o); end
    tick();
    ht_res_valid_i = 1'b0;
    n_tests++; if (err_unexp_res_o !== 1'b1 || res_valid_o !== 4'b0 || outstanding_o !== 5'd0) begin n_fail++; $display("FAIL err_set: got err=%b v=%b out=%0d want 1/0000/0", err_unexp_res_o, res_valid_o, outstanding_o); end
    repeat (3) tick();
    n_tests++; if (err_unexp_res_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_unexp_res_o); end
  endtask

  task automatic test_stats;
    logic [31:0] exp_cnt [4];
`ifdef HT_ARB_STATS_EN
    exp_cnt[0] = 32'd23; exp_cnt[1] = 32'd4; exp_cnt[2] = 32'd4; exp_cnt[3] = 32'd3;
`else
    exp_cnt[0] = 32'd0;  exp_cnt[1] = 32'd0; exp_cnt[2] = 32'd0; exp_cnt[3] = 32'd0;
`endif
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (stat_grant_cnt_o[c] !== exp_cnt[c]) begin n_fail++; $display("FAIL stats[%0d]: got %0d want %0d", c, stat_grant_cnt_o[c], exp_cnt[c]); end
    end
  endtask

  task automatic test_reset_mid;
    cmd_i[3] = mk_cmd(OP_SEARCH, 16'h703);
    cmd_valid_i = 4'b1000;
    settle();
    tick();
    cmd_valid_i = '0;
    n_tests++; if (outstanding_o !== 5'd1 || ht_cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got out=%0d v=%b want 1/1", outstanding_o, ht_cmd_valid_o); end
    rst_i = 1'b0;
    settle();
    n_tests++; if (outstanding_o !== 5'd0 || ht_cmd_valid_o !== 1'b0 || err_unexp_res_o !== 1'b0 || stat_grant_cnt_o[0] !== 32'd0) begin n_fail++; $display("FAIL midrst_clear: got out=%0d v=%b err=%b st0=%0d want 0/0/0/0", outstanding_o, ht_cmd_valid_o, err_unexp_res_o, stat_grant_cnt_o[0]); end
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_full();
    test_init_fence();
    test_result_stall();
    test_error();
    test_stats();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
